fpadd_mc: RTL and testbench

Multicycle IEEE-754 adder/subtractor, parametrised in exponent and fraction width. Adds round-to-nearest-even, special-value handling and status flags. Uses a valid/ready handshake on both input and output. Sits beside the FP unit in the multicycle datapath; the controller holds the instruction until out_valid.

---
 rtl/fpadd_mc.sv | 205 ++++++++++++++++++++
 tb/tb_fpadd_mc.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_mc.sv
// fpadd_mc: multicycle IEEE-754 adder/subtractor with valid/ready on both sides.
// Define FPADD_RNE_EN for round-to-nearest-even; otherwise truncate and saturate on overflow.
module fpadd_mc #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  input  logic                  op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] result,
  output logic [3:0]            flags
);
  localparam int W     = 1 + EXP_W + FRAC_W;
  localparam int M_W   = FRAC_W + 5;
  localparam int HID   = FRAC_W + 3;
  localparam int MAXSH = FRAC_W + 3;
  localparam int SH_W  = $clog2(M_W);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [EXP_W:0]   EXP_ONE_W = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [W-1:0]     QNAN = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, OUT} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [M_W-1:0]   ma_q, ma_d, mb_q, mb_d;
  logic [EXP_W:0]   exp_q, exp_d;
  logic             sign_q, sign_d, sub_q, sub_d;
  logic [W-1:0]     result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  // Operand decode and alignment, consumed in ALIGN.
  logic                sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, is_nan, swap, big_s, lost;
  logic [EXP_W-1:0]    ea, eb, ea_eff, eb_eff, big_e, small_e, diff;
  logic [FRAC_W-1:0]   fa, fb;
  logic [M_W-1:0]      ma_in, mb_in, big_m, small_m, small_sh, aligned;
  logic [SH_W-1:0]     sh;

  assign {sa, ea, fa} = a_q;
  assign {sb, eb, fb} = b_q;
  assign a_nan   = (ea == EXP_ONES) && (fa != '0);
  assign b_nan   = (eb == EXP_ONES) && (fb != '0);
  assign a_inf   = (ea == EXP_ONES) && (fa == '0);
  assign b_inf   = (eb == EXP_ONES) && (fb == '0);
  assign a_zero  = (a_q[W-2:0] == '0);
  assign b_zero  = (b_q[W-2:0] == '0);
  assign is_nan  = a_nan || b_nan || (a_inf && b_inf && (sa != sb));
  assign ea_eff  = (ea == '0) ? EXP_ONE : ea;
  assign eb_eff  = (eb == '0) ? EXP_ONE : eb;
  assign ma_in   = {1'b0, ea != '0, fa, 3'b000};
  assign mb_in   = {1'b0, eb != '0, fb, 3'b000};
  assign swap    = b_q[W-2:0] > a_q[W-2:0];
  assign big_e   = swap ? eb_eff : ea_eff;
  assign small_e = swap ? ea_eff : eb_eff;
  assign big_m   = swap ? mb_in : ma_in;
  assign small_m = swap ? ma_in : mb_in;
  assign big_s   = swap ? sb : sa;
  assign diff    = big_e - small_e;
  assign sh      = (int'(diff) > MAXSH) ? SH_W'(MAXSH) : SH_W'(diff);
  assign small_sh = small_m >> sh;
  assign lost    = |(small_m & ~({M_W{1'b1}} << sh));
  assign aligned = {small_sh[M_W-1:1], small_sh[0] | lost};

  // Add/subtract and rounding datapath.
  logic [M_W-1:0]    sum;
  logic              inc, inexact, hid_r, res_zero;
  logic [FRAC_W+1:0] rnd;
  logic [EXP_W:0]    exp_r;
  logic [EXP_W-1:0]  exp_fld;

  assign sum = sub_q ? (ma_q - mb_q) : (ma_q + mb_q);

`ifdef FPADD_RNE_EN
  localparam logic [W-2:0] OVF_MAG = {EXP_ONES, {FRAC_W{1'b0}}};
  assign inc = ma_q[2] & (ma_q[1] | ma_q[0] | ma_q[3]);
`else
  localparam logic [EXP_W-1:0] EXP_MAXF = EXP_ONES - 1'b1;
  localparam logic [W-2:0]     OVF_MAG  = {EXP_MAXF, {FRAC_W{1'b1}}};
  assign inc = 1'b0;
`endif

  assign rnd      = {1'b0, ma_q[HID:3]} + {{(FRAC_W+1){1'b0}}, inc};
  assign exp_r    = rnd[FRAC_W+1] ? (exp_q + 1'b1) : exp_q;
  assign hid_r    = rnd[FRAC_W+1] | rnd[FRAC_W];
  assign exp_fld  = hid_r ? exp_r[EXP_W-1:0] : '0;
  assign inexact  = |ma_q[2:0];
  assign res_zero = ({exp_fld, rnd[FRAC_W-1:0]} == '0);

  always_comb begin
    // NOTE: every _d starts as its _q, so no branch below can leave a latch behind.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    sub_d    = sub_q;
    result_d = result_q;
    flags_d  = flags_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = {b[W-1] ^ op, b[W-2:0]};
        state_d = ALIGN;
      end
      ALIGN: begin
        state_d = OUT;
        if (is_nan) begin
          result_d = QNAN;
          flags_d  = 4'b0100;
        end else if (a_inf) begin
          result_d = a_q;
          flags_d  = 4'b0000;
        end else if (b_inf) begin
          result_d = b_q;
          flags_d  = 4'b0000;
        end else if (a_zero && b_zero) begin
          result_d = {sa & sb, {(W-1){1'b0}}};
          flags_d  = 4'b1000;
        end else begin
          sign_d  = big_s;
          sub_d   = sa ^ sb;
          exp_d   = {1'b0, big_e};
          ma_d    = big_m;
          mb_d    = aligned;
          state_d = ADD;
        end
      end
      ADD: begin
        // A carry out renormalises right by one, keeping the dropped bit sticky.
        if (sum[M_W-1]) begin
          ma_d  = {1'b0, sum[M_W-1:2], sum[1] | sum[0]};
          exp_d = exp_q + 1'b1;
        end else begin
          ma_d  = sum;
        end
        state_d = NORM;
      end
      NORM: begin
        if (!ma_q[HID] && (ma_q != '0) && (exp_q > EXP_ONE_W)) begin
          ma_d  = ma_q << 1;
          exp_d = exp_q - 1'b1;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        state_d = OUT;
        if (ma_q == '0) begin
          result_d = '0;
          flags_d  = 4'b1000;
        end else if (exp_r >= {1'b0, EXP_ONES}) begin
          result_d = {sign_q, OVF_MAG};
          flags_d  = 4'b0011;
        end else begin
          result_d = {sign_q, exp_fld, rnd[FRAC_W-1:0]};
          flags_d  = {res_zero, 2'b00, inexact};
        end
      end
      OUT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath is reset along with the FSM so result and flags read zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      sub_q    <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples values from before the edge.
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      sub_q    <= sub_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign result    = result_q;
  assign flags     = flags_q;
endmodule

// File: tb/tb_fpadd_mc.sv
// Self-checking bench for fpadd_mc (binary32): directed vectors, handshake corners,
// and random operands against an exact wide-integer reference model.
module tb_fpadd_mc;
`ifdef FPADD_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk, reset, in_valid, in_ready, op_i, out_valid, out_ready;
  logic [31:0] a_i, b_i, result;
  logic [3:0]  flags;

  fpadd_mc #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_i), .b(b_i), .op(op_i), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Exact reference: operands become integers in units of 2^-149, are added exactly,
  // then the sum is rounded back into binary32.
  function automatic logic [299:0] mag(input logic [31:0] v);
    logic [299:0] sig;
    sig = '0;
    sig[23] = (v[30:23] != 8'h00);
    sig[22:0] = v[22:0];
    return (v[30:23] == 8'h00) ? sig : (sig << (v[30:23] - 8'd1));
  endfunction

  function automatic bit is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 0);
  endfunction

  function automatic bit is_inf(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] == 0);
  endfunction

  function automatic logic [35:0] ref_add(input logic [31:0] x, input logic [31:0] y_in, input logic o);
    logic [31:0]  y;
    logic [299:0] va, vb, m, rem, half;
    logic [24:0]  kept;
    logic         s, inexact;
    int           p, sh, e;
    y = {y_in[31] ^ o, y_in[30:0]};
    if (is_nan(x) || is_nan(y) || (is_inf(x) && is_inf(y) && (x[31] != y[31])))
      return {4'b0100, 32'h7FC00000};
    if (is_inf(x)) return {4'b0000, x};
    if (is_inf(y)) return {4'b0000, y};
    va = mag(x);
    vb = mag(y);
    if (x[31] == y[31]) begin m = va + vb; s = x[31]; end
    else if (va >= vb)  begin m = va - vb; s = x[31]; end
    else                begin m = vb - va; s = y[31]; end
    if (m == 0) return {4'b1000, (x[31] == y[31]) ? x[31] : 1'b0, 31'h0};
    p = 0;
    for (int i = 0; i < 300; i++) if (m[i]) p = i;
    if (p <= 23) return {4'b0000, s, 7'h0, m[23:0]};
    sh      = p - 23;
    kept    = 25'(m >> sh);
    rem     = m & ((300'(1) << sh) - 300'(1));
    half    = 300'(1) << (sh - 1);
    e       = sh + 1;
    inexact = (rem != 0);
    if (RNE && ((rem > half) || ((rem == half) && kept[0]))) kept = kept + 25'd1;
    if (kept[24]) begin kept = 25'h0800000; e = e + 1; end
    if (e >= 255) return RNE ? {4'b0011, s, 8'hFF, 23'h0} : {4'b0011, s, 8'hFE, 23'h7FFFFF};
    return {3'b000, inexact, s, e[7:0], kept[22:0]};
  endfunction

  function automatic logic [31:0] special_val();
    case ($urandom_range(0, 7))
      0: return 32'h00000000;
      1: return 32'h80000000;
      2: return 32'h7F800000;
      3: return 32'hFF800000;
      4: return 32'h7FC00000;
      5: return 32'h00000001;
      6: return 32'h7F7FFFFF;
      default: return 32'h00800000;
    endcase
  endfunction

  // One full transaction; optionally stalls the output for 'stall' cycles while
  // offering junk operands that must be ignored.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic o, input int stall,
                        input logic [31:0] er, input logic [3:0] ef, input int el, input string name);
    int waits, lat;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin @(negedge clk); waits++; end
    check({name, "_in_ready"}, in_ready, 1);
    a_i = x; b_i = y; op_i = o; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 64) begin @(posedge clk); lat++; #1; end
    check({name, "_done"}, out_valid, 1);
    check({name, "_res"}, {flags, result}, {ef, er});
    if (el >= 0) check({name, "_lat"}, lat, el);
    check({name, "_busy"}, in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      a_i = $urandom; b_i = $urandom; in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("%s_stall%0d", name, i), {out_valid, in_ready, flags, result}, {2'b10, ef, er});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({name, "_handoff"}, {out_valid, in_ready}, 2'b01);
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        op;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic op,
                              input logic [31:0] res, input logic [3:0] flg, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.res = res; v.flg = flg; v.lat = lat;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] x, y;
    logic        o;
    logic [35:0] exp_v;

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_i = '0; b_i = '0; op_i = 1'b0;
    #12;
    check("reset_state", {in_ready, out_valid, flags, result}, {2'b10, 4'h0, 32'h0});
    @(negedge clk) reset = 1'b1;

    vecs.push_back(mk(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 4));
    vecs.push_back(mk(32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 4'b0000, 6));
    vecs.push_back(mk(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, RNE ? 32'h7F800000 : 32'h7F7FFFFF, 4'b0011, 4));
    vecs.push_back(mk(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b0100, 1));
    vecs.push_back(mk(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b1000, 4));
    vecs.push_back(mk(32'h3F800001, 32'h33800000, 1'b0, RNE ? 32'h3F800002 : 32'h3F800001, 4'b0001, 4));
    vecs.push_back(mk(32'h3FFFFFFF, 32'h33800000, 1'b0, RNE ? 32'h40000000 : 32'h3FFFFFFF, 4'b0001, 4));
    vecs.push_back(mk(32'h3F800000, 32'h00000001, 1'b1, RNE ? 32'h3F800000 : 32'h3F7FFFFF, 4'b0001, 5));
    vecs.push_back(mk(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b1000, 1));
    vecs.push_back(mk(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b1000, 1));
    vecs.push_back(mk(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b1000, 1));
    vecs.push_back(mk(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0100, 1));
    vecs.push_back(mk(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000, 1));
    vecs.push_back(mk(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000, 1));
    vecs.push_back(mk(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000, 4));
    vecs.push_back(mk(32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 4'b0000, 4));
    vecs.push_back(mk(32'h3F800000, 32'h00000000, 1'b0, 32'h3F800000, 4'b0000, 4));

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, 0, vecs[i].res, vecs[i].flg, vecs[i].lat,
             $sformatf("vec%0d", i));

    // Output held for 10 cycles with in_valid asserted: nothing may change or be accepted.
    run_op(32'h3F800000, 32'h40000000, 1'b0, 10, 32'h40400000, 4'b0000, 4, "stall");

    // Reset dropped while the next op sits in NORM (k=2 keeps it there three cycles).
    @(negedge clk);
    a_i = 32'h3F800000; b_i = 32'h3F400000; op_i = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("norm_busy", {out_valid, in_ready}, 2'b00);
    reset = 1'b0;
    #1 check("reset_mid_op", {out_valid, in_ready, flags, result}, {2'b01, 4'h0, 32'h0});
    @(negedge clk) reset = 1'b1;
    run_op(32'h3F800000, 32'h40000000, 1'b0, 0, 32'h40400000, 4'b0000, 4, "after_reset");

    for (int n = 0; n < 300; n++) begin
      x = $urandom;
      y = $urandom;
      o = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        1: y[30:23] = x[30:23];
        2: y[30:23] = x[30:23] ^ 8'($urandom_range(0, 3));
        3: if ($urandom_range(0, 1) == 0) x = special_val(); else y = special_val();
        4: y = x ^ 32'($urandom_range(0, 15));
        default: ;
      endcase
      exp_v = ref_add(x, y, o);
      run_op(x, y, o, 0, exp_v[31:0], exp_v[35:32], -1, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
